// File: rtl/bft_stream_packetizer.sv
// bft_stream_packetizer: transmit-side BFT endpoint.
// Packs a 32-bit valid/ready user stream into 49-bit BFT data packets aimed
// at a fixed leaf/port. Packets are sent only while remote receive slots
// (credits) remain. Freespace-update packets from the BFT return credits.
// A packet rejected by the network with resend is driven again.
// Optional feature macro: BFT_PKT_CNT_EN adds pkt_count and resend_count.
module bft_stream_packetizer #(
  parameter int PACKET_BITS        = 49,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 4,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter logic [NUM_LEAF_BITS-1:0] DEST_LEAF = 4'd1,
  parameter logic [NUM_PORT_BITS-1:0] DEST_PORT = 4'd2,
  parameter logic [NUM_PORT_BITS-1:0] SELF_PORT = 4'd1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PACKET_BITS-1:0]        din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]        dout_leaf_interface2bft,
  input  logic                          resend,
  input  logic [PAYLOAD_BITS-1:0]       s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  output logic [NUM_BRAM_ADDR_BITS:0]   credits,
  output logic                          credit_err
`ifdef BFT_PKT_CNT_EN
  ,
  output logic [31:0]                   pkt_count,
  output logic [15:0]                   resend_count
`endif
);

  // Credit counter spans 0..2^NUM_BRAM_ADDR_BITS, so it needs one extra bit.
  localparam int CW     = NUM_BRAM_ADDR_BITS + 1;
  localparam int RET_W  = 8;
  localparam int SUM_W  = ((CW > RET_W) ? CW : RET_W) + 1;
  localparam logic [CW-1:0] MAX_CREDITS = CW'(1) << NUM_BRAM_ADDR_BITS;

  // Field positions inside a packet.
  localparam int FLAG_BIT  = PAYLOAD_BITS + NUM_BRAM_ADDR_BITS;
  localparam int PORT_LSB  = FLAG_BIT + 1;
  localparam int VALID_BIT = PACKET_BITS - 1;

  logic [PACKET_BITS-1:0]        dout_q, dout_d;
  logic [CW-1:0]                 credits_q, credits_d;
  logic [NUM_BRAM_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic                          credit_err_q, credit_err_d;

  logic             hold;
  logic             accept;
  logic             credit_pkt;
  logic [RET_W-1:0] credit_ret;
  logic [SUM_W-1:0] credit_sum;

  // Leaf, slot and upper payload bits of incoming packets carry nothing for us.
  logic unused_din;
  assign unused_din = ^{din_leaf_bft2interface[VALID_BIT-1:PORT_LSB+NUM_PORT_BITS],
                        din_leaf_bft2interface[FLAG_BIT-1:PAYLOAD_BITS],
                        din_leaf_bft2interface[PAYLOAD_BITS-1:RET_W]};

  // The packet on dout stays put while the network deflects it.
  assign hold     = dout_q[VALID_BIT] && resend;
  assign s_tready = (credits_q != '0) && !hold;
  assign accept   = s_tvalid && s_tready;

  // Only valid credit-flagged packets addressed to our port return credits.
  assign credit_pkt = din_leaf_bft2interface[VALID_BIT] &&
                      din_leaf_bft2interface[FLAG_BIT] &&
                      (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == SELF_PORT);
  assign credit_ret = credit_pkt ? din_leaf_bft2interface[RET_W-1:0] : '0;

  // Next-state logic for the outgoing packet, slot pointer and credit pool.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    dout_d       = '0;
    wr_ptr_d     = wr_ptr_q;
    credit_err_d = credit_err_q;
    credit_sum   = SUM_W'(credits_q) - SUM_W'(accept) + SUM_W'(credit_ret);
    credits_d    = credit_sum[CW-1:0];

    if (hold) begin
      dout_d = dout_q;
    end else if (accept) begin
      dout_d   = {1'b1, DEST_LEAF, DEST_PORT, 1'b0, wr_ptr_q, s_tdata};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    // Returning more slots than exist means the remote side lost sync.
    if (credit_sum > SUM_W'(MAX_CREDITS)) begin
      credits_d    = MAX_CREDITS;
      credit_err_d = 1'b1;
    end
  end

  // Registered packet output and credit state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q       <= '0;
      credits_q    <= MAX_CREDITS;
      wr_ptr_q     <= '0;
      credit_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      dout_q       <= dout_d;
      credits_q    <= credits_d;
      wr_ptr_q     <= wr_ptr_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign credits                 = credits_q;
  assign credit_err              = credit_err_q;

`ifdef BFT_PKT_CNT_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [15:0] resend_count_q, resend_count_d;

  // Accepted-word counter wraps; hold-cycle counter saturates.
  always_comb begin
    pkt_count_d    = pkt_count_q + 32'(accept);
    resend_count_d = resend_count_q;
    if (hold && (resend_count_q != 16'hFFFF)) begin
      resend_count_d = resend_count_q + 16'd1;
    end
  end

  // Statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count_q    <= '0;
      resend_count_q <= '0;
    end else begin
      pkt_count_q    <= pkt_count_d;
      resend_count_q <= resend_count_d;
    end
  end

  assign pkt_count    = pkt_count_q;
  assign resend_count = resend_count_q;
`endif

endmodule

// File: tb/tb_bft_stream_packetizer.sv
// Self-checking bench for bft_stream_packetizer: directed scenarios plus a
// randomized phase, all compared against a cycle-level behavioural model.
module tb_bft_stream_packetizer;

  logic        clk = 1'b0;
  logic        reset;
  logic [48:0] din;
  logic [48:0] dout;
  logic        resend;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  credits;
  logic        credit_err;
`ifdef BFT_PKT_CNT_EN
  logic [31:0] pkt_count;
  logic [15:0] resend_count;
`endif

  bft_stream_packetizer dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_bft2interface  (din),
    .dout_leaf_interface2bft (dout),
    .resend                  (resend),
    .s_tdata                 (s_tdata),
    .s_tvalid                (s_tvalid),
    .s_tready                (s_tready),
    .credits                 (credits),
    .credit_err              (credit_err)
`ifdef BFT_PKT_CNT_EN
    ,
    .pkt_count               (pkt_count),
    .resend_count            (resend_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [48:0] m_dout;
  int          m_credits;
  int          m_ptr;
  bit          m_err;
  longint      m_pkt;
  int          m_rs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [48:0] credit_pkt(input logic [7:0] n);
    logic [3:0] leaf;
    logic [6:0] slot;
    leaf = 4'($urandom);
    slot = 7'($urandom);
    return {1'b1, leaf, 4'd1, 1'b1, slot, 24'd0, n};
  endfunction

  task automatic check_outputs();
    check("dout", 64'(dout), 64'(m_dout));
    check("credits", 64'(credits), 64'(m_credits));
    check("credit_err", 64'(credit_err), 64'(m_err));
`ifdef BFT_PKT_CNT_EN
    check("pkt_count", 64'(pkt_count), 64'(m_pkt[31:0]));
    check("resend_count", 64'(resend_count), 64'(m_rs));
`endif
  endtask

  // One clock cycle: drive, check s_tready, advance model, check outputs.
  task automatic cycle(input bit tv, input logic [31:0] td, input bit rs, input logic [48:0] d);
    bit hold, rdy, acc;
    int ret;
    @(negedge clk);
    s_tvalid = tv;
    s_tdata  = td;
    resend   = rs;
    din      = d;
    #1;
    hold = m_dout[48] && rs;
    rdy  = (m_credits != 0) && !hold;
    check("s_tready", 64'(s_tready), 64'(rdy));
    acc  = tv && rdy;
    ret  = (d[48] && d[39] && d[43:40] == 4'd1) ? int'(d[7:0]) : 0;
    if (hold)     m_dout = m_dout;
    else if (acc) m_dout = {1'b1, 4'd1, 4'd2, 1'b0, 7'(m_ptr), td};
    else          m_dout = '0;
    if (acc) m_ptr = (m_ptr + 1) % 128;
    m_credits = m_credits - int'(acc) + ret;
    if (m_credits > 128) begin
      m_credits = 128;
      m_err     = 1'b1;
    end
    m_pkt = m_pkt + longint'(acc);
    if (hold && m_rs < 65535) m_rs++;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 49'd0);
  endtask

  // Asynchronous reset applied mid-cycle, released on a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    s_tvalid = 1'b0;
    resend   = 1'b0;
    din      = '0;
    #2;
    reset = 1'b1;
    #1;
    m_dout = '0; m_credits = 128; m_ptr = 0; m_err = 1'b0; m_pkt = 0; m_rs = 0;
    check_outputs();
    check("s_tready_rst", 64'(s_tready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int sent;
    logic [63:0] r;
    logic [48:0] d;
    reset = 1'b0; s_tvalid = 1'b0; s_tdata = '0; resend = 1'b0; din = '0;
    #1;
    apply_reset();

    // First word after reset.
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 49'd0);
    check("first_pkt", 64'(dout), 64'h1_1200_DEADBEEF);
    check("first_credits", 64'(credits), 64'd127);

    // Drain all credits with back-to-back words, then keep pushing.
    for (int i = 1; i < 128; i++) cycle(1'b1, $urandom, 1'b0, 49'd0);
    check("drained", 64'(credits), 64'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 49'd0);
    check("no_pkt_at_zero", 64'(dout[48]), 64'd0);

    // Five credits return; exactly five packets go out, first slot wrapped to 0.
    cycle(1'b1, $urandom, 1'b0, credit_pkt(8'd5));
    check("credits_5", 64'(credits), 64'd5);
    sent = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, $urandom, 1'b0, 49'd0);
      if (i == 0) check("wrap_slot", 64'(dout[38:32]), 64'd0);
      if (dout[48]) sent++;
    end
    check("five_sent", 64'(sent), 64'd5);

    // Accept and return one credit in the same cycle at credits=10.
    cycle(1'b0, 32'd0, 1'b0, credit_pkt(8'd10));
    cycle(1'b1, $urandom, 1'b0, credit_pkt(8'd1));
    check("net_zero", 64'(credits), 64'd10);

    // Resend held for three cycles, then the next word follows.
    cycle(1'b1, 32'h12345678, 1'b0, 49'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hBAD0BAD0, 1'b1, 49'd0);
      check("held_pkt", 64'(dout[31:0]), 64'h12345678);
    end
    cycle(1'b1, 32'hCAFEF00D, 1'b0, 49'd0);
    check("after_hold", 64'(dout[31:0]), 64'hCAFEF00D);
    idle(2);

    // Overflow: 120 credits plus 20 returned clamps at 128 and sets the error.
    apply_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0, 49'd0);
    idle(1);
    cycle(1'b0, 32'd0, 1'b0, credit_pkt(8'd20));
    check("clamp", 64'(credits), 64'd128);
    check("err_set", 64'(credit_err), 64'd1);

    // Non-matching input packets are ignored.
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 49'd0);
    cycle(1'b0, 32'd0, 1'b0, {1'b1, 4'd0, 4'd3, 1'b1, 7'd0, 32'd5});
    cycle(1'b0, 32'd0, 1'b0, {1'b1, 4'd0, 4'd1, 1'b0, 7'd0, 32'd5});
    cycle(1'b0, 32'd0, 1'b0, {1'b0, 4'd0, 4'd1, 1'b1, 7'd0, 32'd5});
    check("ignored", 64'(credits), 64'd124);

    // Randomized traffic with resends and mixed input packets.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      r = {$urandom, $urandom};
      d = r[48:0];
      if ($urandom_range(0, 5) == 0) d = credit_pkt(8'($urandom_range(0, (i % 100 == 50) ? 60 : 3)));
      else if (d[43:40] == 4'd1) d[39] = 1'b0;
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0, d);
    end

    // Reset while a packet is being held.
    cycle(1'b1, $urandom, 1'b0, credit_pkt(8'd2));
    cycle(1'b1, $urandom, 1'b1, 49'd0);
    apply_reset();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
